// File: rtl/dram_writeback_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dram_writeback_ctrl
// Desc     : Streams output-buffer rows to DRAM as DATA_IN_DRAM_WIDTH words,
//            LSB word first, from a programmable start address up to a finish
//            address. Optional lane ReLU at row capture: define WB_RELU_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dram_writeback_ctrl #(
   parameter int DRAM_ADDR_WIDTH    = 18,
   parameter int OUTPUT_ADDR_WIDTH  = 16,
   parameter int DATA_IN_DRAM_WIDTH = 32,
   parameter int N_COLS_ARRAY       = 16,
   parameter int O_WIDTH            = 8
) (
   input  logic                              clk_i,
   input  logic                              general_rst_i,
   input  logic                              start_i,
   input  logic [OUTPUT_ADDR_WIDTH-1:0]      output_count_i,
   input  logic [DRAM_ADDR_WIDTH-1:0]        output_start_addr_dram_i,
   input  logic [DRAM_ADDR_WIDTH-1:0]        output_finish_addr_dram_i,
   output logic                              out_rd_en_o,
   output logic [OUTPUT_ADDR_WIDTH-1:0]      out_rd_address_o,
   input  logic [O_WIDTH*N_COLS_ARRAY-1:0]   out_data_i,
   output logic                              dram_wr_en_o,
   input  logic                              dram_wr_ready_i,
   output logic [DRAM_ADDR_WIDTH-1:0]        dram_wr_address_o,
   output logic [DATA_IN_DRAM_WIDTH-1:0]     dram_wr_data_o,
   output logic                              writeback_done_o,
   output logic [2:0]                        dram_wb_state_o
);

   localparam int c_ROW_W       = O_WIDTH * N_COLS_ARRAY;
   localparam int WORDS_PER_ROW = (c_ROW_W + DATA_IN_DRAM_WIDTH - 1) / DATA_IN_DRAM_WIDTH;
   localparam int c_PAD_W       = WORDS_PER_ROW * DATA_IN_DRAM_WIDTH;
   localparam int c_WORD_W      = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_READ  = 3'b001,
      S_WAIT  = 3'b010,
      S_WRITE = 3'b011,
      S_DONE  = 3'b100
   } state_t;

   state_t                          r_state;
   state_t                          w_next_state;
   logic [OUTPUT_ADDR_WIDTH-1:0]    r_row;
   logic [OUTPUT_ADDR_WIDTH-1:0]    r_count;
   logic [c_WORD_W-1:0]             r_word;
   logic [DRAM_ADDR_WIDTH-1:0]      r_addr;
   logic [DRAM_ADDR_WIDTH-1:0]      r_finish;
   logic [c_ROW_W-1:0]              r_row_data;
   logic [c_ROW_W-1:0]              w_row_capture;
   logic [c_PAD_W-1:0]              w_row_padded;
   logic [DATA_IN_DRAM_WIDTH-1:0]   w_words [WORDS_PER_ROW];
   logic                            w_accept;
   logic                            w_last_word;
   logic                            w_last_row;
   logic                            w_at_finish;

`ifdef WB_RELU_EN
   for (genvar gl = 0; gl < N_COLS_ARRAY; gl++) begin : g_relu
      assign w_row_capture[gl*O_WIDTH +: O_WIDTH] =
         out_data_i[gl*O_WIDTH + O_WIDTH - 1] ? '0 : out_data_i[gl*O_WIDTH +: O_WIDTH];
   end
`else
   assign w_row_capture = out_data_i;
`endif

   // Zero-extend so a partial last word reads zeros above the row width.
   assign w_row_padded = c_PAD_W'(r_row_data);

   for (genvar gw = 0; gw < WORDS_PER_ROW; gw++) begin : g_word
      assign w_words[gw] = w_row_padded[gw*DATA_IN_DRAM_WIDTH +: DATA_IN_DRAM_WIDTH];
   end

   assign w_accept    = (r_state == S_WRITE) && dram_wr_ready_i;
   assign w_last_word = (r_word == c_WORD_W'(WORDS_PER_ROW - 1));
   assign w_last_row  = (r_row == (r_count - 1'b1));
   assign w_at_finish = (r_addr == r_finish);

   assign dram_wb_state_o = r_state;

   always_ff @(posedge clk_i or posedge general_rst_i) begin
      if (general_rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state      = r_state;
      out_rd_en_o       = 1'b0;
      out_rd_address_o  = '0;
      dram_wr_en_o      = 1'b0;
      dram_wr_address_o = '0;
      dram_wr_data_o    = '0;
      writeback_done_o  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_next_state = (output_count_i != '0) ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            out_rd_en_o      = 1'b1;
            out_rd_address_o = r_row;
            w_next_state     = S_WAIT;
         end
         S_WAIT: begin
            w_next_state = S_WRITE;
         end
         S_WRITE: begin
            dram_wr_en_o      = 1'b1;
            dram_wr_address_o = r_addr;
            dram_wr_data_o    = w_words[r_word];
            // The finish bound wins even in the middle of a row.
            if (w_accept) begin
               if (w_at_finish || (w_last_word && w_last_row)) begin
                  w_next_state = S_DONE;
               end else if (w_last_word) begin
                  w_next_state = S_READ;
               end
            end
         end
         S_DONE: begin
            writeback_done_o = 1'b1;
            if (!start_i) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge general_rst_i) begin
      if (general_rst_i) begin
         r_row      <= '0;
         r_count    <= '0;
         r_word     <= '0;
         r_addr     <= '0;
         r_finish   <= '0;
         r_row_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i && (output_count_i != '0)) begin
                  r_count  <= output_count_i;
                  r_addr   <= output_start_addr_dram_i;
                  r_finish <= output_finish_addr_dram_i;
                  r_row    <= '0;
                  r_word   <= '0;
               end
            end
            S_WAIT: begin
               r_row_data <= w_row_capture;
            end
            S_WRITE: begin
               if (w_accept) begin
                  r_addr <= r_addr + 1'b1;
                  if (!w_at_finish) begin
                     if (w_last_word) begin
                        r_word <= '0;
                        r_row  <= r_row + 1'b1;
                     end else begin
                        r_word <= r_word + 1'b1;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire
